// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline control slice.
// Holds the instruction codes, register sentinel and status codes the
// control logic decodes, the processor-status state enum and a helper that
// classifies a status word as exceptional.
package y86_pkg;

    // Instruction codes (icode field)
    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    // "No register" identifier
    localparam logic [3:0] RNONE = 4'hF;

    // Status codes
    localparam logic [3:0] S_AOK = 4'd1;
    localparam logic [3:0] S_HLT = 4'd2;
    localparam logic [3:0] S_ADR = 4'd3;
    localparam logic [3:0] S_INS = 4'd4;

    // Processor-status state machine
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Any status other than AOK is an exception (HLT included).
    function automatic logic is_exc(input logic [3:0] stat);
        return stat != S_AOK;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classifier for the Y86-64 pipeline.
// Ports:
//   D_icode, E_icode, M_icode : icodes held in the D, E and M registers
//   d_srcA, d_srcB            : decode-stage source register IDs
//   E_dstM                    : memory destination of the instruction in E
//   e_Cnd                     : condition evaluated in execute
//   lu                        : load/use hazard (load in E feeds decode)
//   rt                        : ret somewhere in D, E or M
//   mp                        : jump in E was predicted taken but not taken
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    output logic       lu,
    output logic       rt,
    output logic       mp
);

    logic e_is_load;

    always_comb begin
        e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
        // RNONE never matches: a load with no destination cannot forward.
        lu = e_is_load && (E_dstM != RNONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        // Branches are predicted taken, so a false condition is a mispredict.
        mp = (E_icode == I_JXX) && !e_Cnd;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage Y86-64 pipeline.
// Turns hazard terms into stall/bubble controls, owns the F_predPC register,
// gates condition-code writes and runs the INIT/RUN/HALT status machine.
// Also counts RUN cycles and retired instructions for CPI measurement.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   f_predPC            : next-PC prediction from fetch
//   D/E/M/W_icode etc.  : pipeline register fields used for hazard detection
//   m_stat, W_stat      : memory and write-back status
//   F_predPC            : registered fetch PC prediction
//   F_stall .. W_stall  : pipeline register stall/bubble controls
//   set_cc              : condition-code write enable
//   halted, stat_out    : HALT indication and latched final status
//   cycle_cnt, instr_cnt: RUN cycle and retired-instruction counters
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      f_predPC,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_stat,
    output logic [63:0]      F_predPC,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [3:0]       stat_out,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [63:0]      pred_pc_q, pred_pc_d;
    logic [3:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic lu, rt, mp;
    logic m_exc, w_exc;
    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cc_en;

    hazard_detect u_hazard (
        .D_icode (D_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .E_icode (E_icode),
        .E_dstM  (E_dstM),
        .e_Cnd   (e_Cnd),
        .M_icode (M_icode),
        .lu      (lu),
        .rt      (rt),
        .mp      (mp)
    );

    always_comb begin
        m_exc       = is_exc(m_stat);
        w_exc       = is_exc(W_stat);
        state_d     = state_q;
        pred_pc_d   = pred_pc_q;
        stat_d      = stat_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        f_stall     = 1'b0;
        d_stall     = 1'b0;
        d_bubble    = 1'b0;
        e_bubble    = 1'b0;
        m_bubble    = 1'b0;
        w_stall     = 1'b0;
        cc_en       = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                // Flush D/E/M so nothing stale enters the pipe.
                d_bubble = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                f_stall  = lu || rt;
                // D may never be both held and flushed; a mispredict
                // squashes D, so it overrides the load/use hold.
                d_stall  = lu && !mp;
                d_bubble = mp || (rt && !lu);
                e_bubble = mp || lu;
                m_bubble = m_exc || w_exc;
                w_stall  = w_exc;
                // An older excepting instruction must not see CC changes.
                cc_en    = (E_icode == I_OPQ) && !m_exc && !w_exc;

                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (!f_stall) begin
                    pred_pc_d = f_predPC;
                end
                if ((W_icode != I_NOP) && !w_exc && !w_stall) begin
                    instr_cnt_d = instr_cnt_q + CNT_W'(1);
                end
                if (w_exc) begin
                    state_d = ST_HALT;
                    stat_d  = W_stat;
                end
            end
            ST_HALT: begin
                // Freeze architectural state; only rst leaves HALT.
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                w_stall  = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            pred_pc_q   <= 64'd0;
            stat_q      <= S_AOK;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pred_pc_q   <= pred_pc_d;
            stat_q      <= stat_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign F_predPC  = pred_pc_q;
    assign F_stall   = f_stall;
    assign D_stall   = d_stall;
    assign D_bubble  = d_bubble;
    assign E_bubble  = e_bubble;
    assign M_bubble  = m_bubble;
    assign W_stall   = w_stall;
    assign set_cc    = cc_en;
    assign halted    = (state_q == ST_HALT);
    assign stat_out  = stat_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver applies each cycle's inputs at the
// falling edge, computes the expected outputs from a behavioural model of the
// control rules and queues them; a monitor samples the DUT just before the
// next rising edge and compares against the queue head.
module tb_pipe_ctrl;

    localparam int CNT_W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] f_predPC;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_Cnd;
    logic [3:0]  m_stat, W_icode, W_stat;
    logic [63:0] F_predPC;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic        set_cc, halted;
    logic [3:0]  stat_out;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_predPC  (f_predPC),
        .D_icode   (D_icode),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .E_icode   (E_icode),
        .E_dstM    (E_dstM),
        .e_Cnd     (e_Cnd),
        .M_icode   (M_icode),
        .m_stat    (m_stat),
        .W_icode   (W_icode),
        .W_stat    (W_stat),
        .F_predPC  (F_predPC),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .set_cc    (set_cc),
        .halted    (halted),
        .stat_out  (stat_out),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    typedef struct {
        logic        rst;
        logic [63:0] fpc;
        logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
        logic        e_Cnd;
        logic [3:0]  m_stat, W_icode, W_stat;
    } stim_t;

    typedef struct {
        logic [63:0] pc;
        logic        fs, ds, db, eb, mb, ws, cc, hl;
        logic [3:0]  st;
        logic [63:0] cy, in;
    } exp_t;

    exp_t  sbq[$];
    stim_t nx;
    exp_t  mon_e;

    // Reference model: mode 0 = INIT, 1 = RUN, 2 = HALT
    int          m_mode;
    logic [63:0] m_pc, m_cy, m_in;
    logic [3:0]  m_st;

    int vectors     = 0;
    int miscompares = 0;

    task automatic quiet(input logic [63:0] fpc);
        nx.rst     = 1'b0;
        nx.fpc     = fpc;
        nx.D_icode = 4'd1;
        nx.d_srcA  = 4'hF;
        nx.d_srcB  = 4'hF;
        nx.E_icode = 4'd1;
        nx.E_dstM  = 4'hF;
        nx.e_Cnd   = 1'b1;
        nx.M_icode = 4'd1;
        nx.m_stat  = 4'd1;
        nx.W_icode = 4'd1;
        nx.W_stat  = 4'd1;
    endtask

    task automatic step();
        exp_t e;
        logic lu, rt, mp, mx, wx;
        @(negedge clk);
        rst      = nx.rst;
        f_predPC = nx.fpc;
        D_icode  = nx.D_icode;
        d_srcA   = nx.d_srcA;
        d_srcB   = nx.d_srcB;
        E_icode  = nx.E_icode;
        E_dstM   = nx.E_dstM;
        e_Cnd    = nx.e_Cnd;
        M_icode  = nx.M_icode;
        m_stat   = nx.m_stat;
        W_icode  = nx.W_icode;
        W_stat   = nx.W_stat;

        // Hazard rules: MRMOVQ=5, POPQ=11, RET=9, JXX=7, OPQ=6, RNONE=F, AOK=1
        lu = (nx.E_icode == 4'd5 || nx.E_icode == 4'd11) && nx.E_dstM != 4'hF &&
             (nx.E_dstM == nx.d_srcA || nx.E_dstM == nx.d_srcB);
        rt = (nx.D_icode == 4'd9) || (nx.E_icode == 4'd9) || (nx.M_icode == 4'd9);
        mp = (nx.E_icode == 4'd7) && !nx.e_Cnd;
        mx = nx.m_stat != 4'd1;
        wx = nx.W_stat != 4'd1;

        e.pc = m_pc; e.cy = m_cy; e.in = m_in; e.st = m_st;
        e.hl = (m_mode == 2);
        if (m_mode == 0) begin
            e.fs = 0; e.ds = 0; e.db = 1; e.eb = 1; e.mb = 1; e.ws = 0; e.cc = 0;
        end else if (m_mode == 1) begin
            e.fs = lu || rt;
            e.ds = lu && !mp;
            e.db = mp || (rt && !lu);
            e.eb = mp || lu;
            e.mb = mx || wx;
            e.ws = wx;
            e.cc = (nx.E_icode == 4'd6) && !mx && !wx;
        end else begin
            e.fs = 1; e.ds = 1; e.db = 0; e.eb = 1; e.mb = 1; e.ws = 1; e.cc = 0;
        end
        sbq.push_back(e);

        // Advance the model to the state after the coming rising edge.
        if (nx.rst) begin
            m_mode = 0; m_pc = 0; m_cy = 0; m_in = 0; m_st = 4'd1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_cy = m_cy + 1;
            if (!e.fs) m_pc = nx.fpc;
            if (nx.W_icode != 4'd1 && !wx && !e.ws) m_in = m_in + 1;
            if (wx) begin
                m_mode = 2;
                m_st   = nx.W_stat;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s vector=%0d actual=0x%0h required=0x%0h", nm, vectors, act, req);
        end
    endtask

    // Monitor: sample just before the rising edge of the driven cycle.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                vectors++;
                chk("F_predPC",  F_predPC,        mon_e.pc);
                chk("F_stall",   64'(F_stall),    64'(mon_e.fs));
                chk("D_stall",   64'(D_stall),    64'(mon_e.ds));
                chk("D_bubble",  64'(D_bubble),   64'(mon_e.db));
                chk("E_bubble",  64'(E_bubble),   64'(mon_e.eb));
                chk("M_bubble",  64'(M_bubble),   64'(mon_e.mb));
                chk("W_stall",   64'(W_stall),    64'(mon_e.ws));
                chk("set_cc",    64'(set_cc),     64'(mon_e.cc));
                chk("halted",    64'(halted),     64'(mon_e.hl));
                chk("stat_out",  64'(stat_out),   64'(mon_e.st));
                chk("cycle_cnt", 64'(cycle_cnt),  mon_e.cy);
                chk("instr_cnt", 64'(instr_cnt),  mon_e.in);
            end
        end
    end

    initial begin
        int halt_len;
        logic [3:0] wpat [10];
        wpat = '{4'd6, 4'd1, 4'd2, 4'd1, 4'd5, 4'd0, 4'd1, 4'd3, 4'd1, 4'd10};

        quiet(64'd0);
        rst = 1'b1; f_predPC = 0; D_icode = 1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 1; E_dstM = 4'hF; e_Cnd = 1; M_icode = 1; m_stat = 1;
        W_icode = 1; W_stat = 1;
        @(posedge clk);
        m_mode = 0; m_pc = 0; m_cy = 0; m_in = 0; m_st = 4'd1;

        // Reset two cycles, then INIT
        nx.rst = 1'b1; step(); step();
        quiet(64'h10); step();
        quiet(64'h18); step();

        // Load/use
        quiet(64'h1234); nx.E_icode = 4'd5; nx.E_dstM = 4'd3; nx.d_srcA = 4'd3; step();
        quiet(64'h20); step();

        // Ret drain and release
        quiet(64'h28); nx.D_icode = 4'd9; step();
        quiet(64'h30); nx.E_icode = 4'd9; step();
        quiet(64'h38); nx.M_icode = 4'd9; step();
        quiet(64'h3C); step();

        // Mispredict
        quiet(64'h40); nx.E_icode = 4'd7; nx.e_Cnd = 1'b0; step();
        quiet(64'h44); step();

        // Load/use with ret in M
        quiet(64'h48); nx.E_icode = 4'd11; nx.E_dstM = 4'd2; nx.d_srcB = 4'd2;
        nx.M_icode = 4'd9; step();

        // Counters: reset, INIT, then 10 RUN cycles with 6 retirements
        quiet(0); nx.rst = 1'b1; step();
        quiet(0); step();
        for (int i = 0; i < 10; i++) begin
            quiet(64'(i * 4)); nx.W_icode = wpat[i]; step();
        end
        quiet(64'h100); step();
        quiet(64'h104); nx.rst = 1'b1; step();
        quiet(64'h108); step();
        quiet(64'h10C); step();

        // Halt on HLT in W
        quiet(64'h200); nx.W_icode = 4'd0; nx.W_stat = 4'd2; step();
        for (int i = 0; i < 4; i++) begin
            quiet(64'h300 + 64'(i)); nx.E_icode = 4'd6; nx.W_icode = 4'd6; step();
        end

        // Reset, then ADR in M while OPQ in E, then ADR reaches W
        quiet(0); nx.rst = 1'b1; step();
        quiet(0); step();
        quiet(64'h50); step();
        quiet(64'h58); nx.m_stat = 4'd3; nx.E_icode = 4'd6; step();
        quiet(64'h60); nx.W_stat = 4'd3; nx.W_icode = 4'd5; nx.E_icode = 4'd6; step();
        quiet(64'h68); step();
        quiet(64'h70); step();

        // Random traffic
        halt_len = 0;
        for (int i = 0; i < 3000; i++) begin
            nx.fpc     = {$urandom, $urandom};
            nx.D_icode = 4'($urandom_range(0, 11));
            nx.E_icode = 4'($urandom_range(0, 11));
            nx.M_icode = 4'($urandom_range(0, 11));
            nx.W_icode = 4'($urandom_range(0, 11));
            nx.d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            nx.d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            nx.E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            nx.e_Cnd   = 1'($urandom_range(0, 1));
            nx.m_stat  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            nx.W_stat  = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            halt_len   = (m_mode == 2) ? halt_len + 1 : 0;
            nx.rst     = ($urandom_range(0, 149) == 0) || (halt_len > 5);
            step();
        end

        repeat (3) @(posedge clk);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage Y86-64 pipeline.
- Detects load/use, ret and mispredicted-branch hazards and drives stall/bubble controls for the F, D, E, M and W pipeline registers.
- Owns the F_predPC register, gates condition-code updates, and runs the processor-status state machine that freezes the pipe when an exception or halt reaches W.
- Keeps cycle and retired-instruction counters for CPI measurement.

Parameters:
- CNT_W, 64, width of the cycle and retired-instruction counters.

Ports:
- clk  in  1  clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- rst  in  1  synchronous reset, active-high.
- f_predPC  in  64  predicted next PC from the fetch-stage predictor.
- D_icode  in  4  icode in the D register.
- d_srcA, d_srcB  in  4 each  decode-stage source register IDs.
- E_icode  in  4  icode in the E register.
- E_dstM  in  4  E-stage memory destination register.
- e_Cnd  in  1  branch/cmov condition computed in execute.
- M_icode  in  4  icode in the M register.
- m_stat  in  4  memory-stage status.
- W_icode  in  4  icode in the W register.
- W_stat  in  4  write-back-stage status.
- F_predPC  out  64  registered fetch PC prediction.
- F_stall  out  1  hold the F register.
- D_stall  out  1  hold the D register.
- D_bubble  out  1  load a NOP into the D register.
- E_bubble  out  1  load a NOP into the E register.
- M_bubble  out  1  load a NOP into the M register.
- W_stall  out  1  hold the W register.
- set_cc  out  1  condition-code write enable.
- halted  out  1  state is HALT.
- stat_out  out  4  latched final status (AOK while running).
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Encodings (from package): NOP=1, JXX=7, RET=9, MRMOVQ=5, POPQ=11, OPQ=6, RNONE=0xF; status AOK=1, HLT=2, ADR=3, INS=4. "exc(x)" means x is not AOK.
- State machine: INIT -> RUN -> HALT.
  - rst=1 in any cycle, including mid-run or while in HALT, forces INIT on the next edge.
  - INIT lasts exactly one cycle, then goes to RUN.
  - RUN goes to HALT on the edge where exc(W_stat) is true.
  - HALT is left only by rst.
- Hazard terms (combinational, used in RUN):
  - lu = (E_icode is MRMOVQ or POPQ) and E_dstM is not RNONE and (E_dstM == d_srcA or E_dstM == d_srcB).
  - rt = RET present in D_icode, E_icode or M_icode.
  - mp = (E_icode == JXX) and not e_Cnd.
- RUN outputs:
  - F_stall = lu or rt.
  - D_stall = lu.
  - D_bubble = mp or (rt and not lu).
  - E_bubble = mp or lu.
  - M_bubble = exc(m_stat) or exc(W_stat).
  - W_stall = exc(W_stat).
  - set_cc = (E_icode == OPQ) and not exc(m_stat) and not exc(W_stat).
- Simultaneous events:
  - D_stall and D_bubble are never both 1; lu has priority (lu+rt gives stall, not bubble).
  - mp together with lu: the bubble wins in E; D_stall=1 and D_bubble=1 is illegal, so in that case D_bubble=1 and D_stall=0.
  - Verify: mp with lu cannot occur architecturally (E holds a JXX, not a load), but the stated priority is still required.
- INIT outputs:
  - D_bubble, E_bubble and M_bubble = 1; all stalls 0; set_cc = 0.
  - F_predPC = 0 (synchronous with rst). No counting.
- HALT outputs:
  - F_stall, D_stall and W_stall = 1; E_bubble and M_bubble = 1; D_bubble = 0; set_cc = 0.
  - halted = 1; stat_out holds the W_stat captured on the RUN->HALT edge.
- F_predPC register:
  - Reset value 0.
  - In RUN, loads f_predPC on each edge when F_stall=0; otherwise holds.
  - Holds in HALT.
- Counters:
  - Both reset to 0.
  - cycle_cnt increments every RUN cycle.
  - instr_cnt increments in RUN when W_icode is not NOP, not exc(W_stat), and W_stall=0.
  - Both wrap modulo 2^CNT_W and freeze in HALT.
- Output reset values: stat_out = AOK, halted = 0.

Decomposition:
- Package y86_pkg: icode constants, status codes AOK/HLT/ADR/INS, RNONE, state enum {INIT, RUN, HALT}.
- One sub-module, hazard_detect: purely combinational, computes lu/rt/mp. Its outputs feed the stall/bubble muxes in pipe_ctrl.

Test Plan:
- Load/use: rst for 2 cycles, then E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; F_predPC holds.
- Ret drain: D_icode=9 for one cycle, then E_icode=9, then M_icode=9, no lu -> F_stall=1 and D_bubble=1 in each of the 3 cycles; F_predPC frozen; released in the cycle after M.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; F_predPC loads f_predPC=0x40.
- Combined: E_icode=11, E_dstM=2, d_srcB=2, M_icode=9 -> D_stall=1, D_bubble=0, F_stall=1.
- Halt: W_stat=2 (HLT) with W_icode=0 -> next cycle halted=1, stat_out=2; counters freeze; W_stall=1 persists. Same flow with m_stat=3 asserts M_bubble=1 and set_cc=0 while E_icode=6.
- Reset/counters: run 10 RUN cycles with 6 non-NOP AOK retirements -> cycle_cnt=10, instr_cnt=6; assert rst mid-run -> next cycle INIT: all counters 0, F_predPC=0, bubbles asserted.
